// File: rtl/fft_latency_meter.sv
// -----------------------------------------------------------------------------
// fft_latency_meter
//   Counts the FFT core's processing latency in clock cycles. Counting starts
//   on the cycle en_FFT is accepted and stops on the cycle finish_FFT is
//   sampled. The count saturates at SAT_VAL. A sequential double-dabble
//   engine converts the count to 4-digit packed BCD. The result is presented
//   with a one-cycle valid strobe for the downstream 7-segment driver.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en_FFT     in   FFT start strobe; accepted only in IDLE
//   finish_FFT in   FFT done strobe; accepted only in COUNT
//   busy       out  high while counting or converting
//   bcd_out    out  packed BCD result, [3:0] = units; held between results
//   bcd_valid  out  one-cycle pulse when bcd_out/overflow update
//   overflow   out  the measured latency exceeded SAT_VAL
// -----------------------------------------------------------------------------
module fft_latency_meter #(
  parameter int CNT_W   = 14,
  parameter int SAT_VAL = 9999,
  parameter int DIGITS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_FFT,
  input  logic        finish_FFT,
  output logic        busy,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + CNT_W;
  // The iteration counter must be able to reach CNT_W + 1.
  localparam int IT_W  = $clog2(CNT_W + 2);

  localparam logic [CNT_W-1:0] SAT_LIMIT = CNT_W'(SAT_VAL);
  localparam logic [IT_W-1:0]  LAST_IT   = IT_W'(CNT_W);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [IT_W-1:0]  iter_q, iter_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic             ovf_out_q, ovf_out_d;

  // Add-3 correction for each BCD nibble before the shift. The sum is kept
  // to 4 bits; a nibble of at most 9 plus 3 cannot wrap.
  logic [BCD_W-1:0] adj_bcd;
  logic [SR_W-1:0]  sr_shifted;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    logic [3:0] nib;
    assign nib = sr_q[CNT_W + 4*gi +: 4];
    assign adj_bcd[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  assign sr_shifted = {adj_bcd[BCD_W-2:0], sr_q[CNT_W-1:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sr_d      = sr_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    valid_d   = 1'b0;
    ovf_out_d = ovf_out_q;
    case (state_q)
      S_IDLE: begin
        if (en_FFT) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        // The finishing edge still counts, so a one-cycle job reads 1.
        if (cnt_q < SAT_LIMIT) cnt_d = cnt_q + 1'b1;
        else                   ovf_d = 1'b1;
        if (finish_FFT) begin
          iter_d  = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // iter_q == 0 is the load cycle; iterations 1..CNT_W are shifts.
        if (iter_q == '0) begin
          sr_d   = {{BCD_W{1'b0}}, cnt_q};
          iter_d = IT_W'(1);
        end else begin
          sr_d   = sr_shifted;
          iter_d = iter_q + 1'b1;
          if (iter_q == LAST_IT) state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d     = sr_q[SR_W-1 -: BCD_W];
        ovf_out_d = ovf_q;
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sr_q      <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sr_q      <= sr_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign busy      = (state_q == S_COUNT) || (state_q == S_CONVERT);
  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;
  assign overflow  = ovf_out_q;

endmodule

// File: tb/tb_fft_latency_meter.sv
module tb_fft_latency_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_FFT = 1'b0;
  logic        finish_FFT = 1'b0;
  logic        busy;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        overflow;

  fft_latency_meter dut (
    .clk        (clk),
    .rst        (rst),
    .en_FFT     (en_FFT),
    .finish_FFT (finish_FFT),
    .busy       (busy),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] prev_bcd = 16'h0000;
  logic        prev_ovf = 1'b0;

  typedef struct {
    int          n;
    int          gap;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One measurement: en_FFT sampled at E0, finish_FFT sampled at En.
  // both     : finish_FFT also high at E0 (must be ignored in IDLE)
  // repulse  : cycle index in COUNT where en_FFT is pulsed again (0 = none)
  // fin_conv : cycle after En where finish_FFT is pulsed (0 = none)
  task automatic run(input string tag, input int n, input int gap, input logic both,
                     input int repulse, input int fin_conv,
                     input logic [15:0] exp_bcd, input logic exp_ovf);
    int   got;
    logic busy_ok;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    en_FFT = 1'b1;
    finish_FFT = both;
    @(posedge clk);
    #1;
    chk({tag, " busy_at_start"}, busy, 1'b1);
    chk({tag, " valid_low_at_start"}, bcd_valid, 1'b0);
    chk({tag, " bcd_hold"}, bcd_out, prev_bcd);
    chk({tag, " ovf_hold"}, overflow, prev_ovf);
    @(negedge clk);
    en_FFT = 1'b0;
    finish_FFT = 1'b0;
    for (int i = 1; i < n; i++) begin
      en_FFT = (i == repulse);
      @(negedge clk);
    end
    en_FFT = 1'b0;
    finish_FFT = 1'b1;
    @(posedge clk);
    @(negedge clk);
    finish_FFT = 1'b0;
    got = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      finish_FFT = (k == fin_conv);
      @(posedge clk);
      #1;
      if (bcd_valid) begin
        got = k;
        break;
      end
      if (busy !== (k < 15)) busy_ok = 1'b0;
      @(negedge clk);
    end
    finish_FFT = 1'b0;
    chk({tag, " latency"}, got, 16);
    chk({tag, " bcd_out"}, bcd_out, exp_bcd);
    chk({tag, " overflow"}, overflow, exp_ovf);
    chk({tag, " busy_profile"}, busy_ok, 1'b1);
    chk({tag, " busy_after"}, busy, 1'b0);
    $display("run %s n=%0d lat=%0d bcd=%h ovf=%b", tag, n, got, bcd_out, overflow);
    prev_bcd = exp_bcd;
    prev_ovf = exp_ovf;
  endtask

  initial begin
    vecs[0] = '{1,     2, 16'h0001, 1'b0};
    vecs[1] = '{9,     0, 16'h0009, 1'b0};
    vecs[2] = '{10,    3, 16'h0010, 1'b0};
    vecs[3] = '{1234,  0, 16'h1234, 1'b0};
    vecs[4] = '{9999,  1, 16'h9999, 1'b0};
    vecs[5] = '{12000, 0, 16'h9999, 1'b1};
    vecs[6] = '{5,     2, 16'h0005, 1'b0};
    vecs[7] = '{407,   0, 16'h0407, 1'b0};

    // Reset state.
    #12;
    chk("reset busy", busy, 1'b0);
    chk("reset bcd_out", bcd_out, 16'h0000);
    chk("reset valid", bcd_valid, 1'b0);
    chk("reset overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run($sformatf("vec%0d", v), vecs[v].n, vecs[v].gap, 1'b0, 0, 0,
          vecs[v].bcd, vecs[v].ovf);
    end

    run("en_and_finish", 3, 1, 1'b1, 0, 0, 16'h0003, 1'b0);
    run("en_repulse", 20, 1, 1'b0, 5, 0, 16'h0020, 1'b0);
    run("finish_in_convert", 57, 1, 1'b0, 0, 5, 16'h0057, 1'b0);
    run("back_to_back", 8, 0, 1'b0, 0, 0, 16'h0008, 1'b0);

    // Asynchronous reset in the middle of COUNT.
    begin
      logic seen;
      @(negedge clk);
      en_FFT = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en_FFT = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midcount_rst busy", busy, 1'b0);
      chk("midcount_rst bcd_out", bcd_out, 16'h0000);
      chk("midcount_rst overflow", overflow, 1'b0);
      chk("midcount_rst valid", bcd_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      finish_FFT = 1'b1;  // orphan finish in IDLE
      @(negedge clk);
      finish_FFT = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk);
        #1;
        if (bcd_valid || busy) seen = 1'b1;
      end
      chk("midcount_rst no_output", seen, 1'b0);
      $display("run midcount_rst bcd=%h ovf=%b", bcd_out, overflow);
      prev_bcd = 16'h0000;
      prev_ovf = 1'b0;
    end

    run("after_reset", 2, 0, 1'b0, 0, 0, 16'h0002, 1'b0);

    @(posedge clk);
    #1;
    chk("final valid_pulse_width", bcd_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_latency_meter.md
Name: fft_latency_meter

Overview:
- Measures the FFT core's processing latency in clock cycles, from the cycle `en_FFT` is accepted to the cycle `finish_FFT` is sampled.
- Converts the binary cycle count to 4-digit packed BCD with a sequential double-dabble engine.
- Presents the result with a one-cycle valid strobe.
- Sits directly upstream of the 7-segment display driver, which latches `bcd_out` on `bcd_valid` and only multiplexes digits.

Parameters:
- CNT_W, 14, width of the binary cycle counter and the number of double-dabble iterations.
- SAT_VAL, 9999, saturation limit of the counter; the largest value displayable on 4 decimal digits.
- DIGITS, 4, number of BCD nibbles produced; fixed at 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_FFT  input  1  FFT start strobe; a level is accepted only in IDLE.
- finish_FFT  input  1  FFT done strobe; a level is accepted only in COUNT.
- busy  output  1  high in COUNT and CONVERT.
- bcd_out  output  16  packed BCD result; [3:0] = units, [15:12] = thousands. Held until the next result.
- bcd_valid  output  1  one-cycle pulse when `bcd_out` updates.
- overflow  output  1  measured latency exceeded SAT_VAL; updated together with `bcd_out`.

Behaviour:
- Reset (asynchronous, immediate, valid at any time including mid-COUNT or mid-CONVERT):
  - state = IDLE; counter = 0; shift register = 0.
  - busy = 0, bcd_out = 16'h0000, bcd_valid = 0, overflow = 0.
  - Any in-flight measurement is discarded and nothing is emitted.
- States: IDLE, COUNT, CONVERT, DONE (one-hot encoding permitted).
- IDLE:
  - On an edge where `en_FFT` = 1: counter <= 0, internal ovf flag <= 0, go to COUNT.
  - `finish_FFT` is ignored, including when asserted simultaneously with `en_FFT`.
- COUNT:
  - Every edge: if counter < SAT_VAL, counter <= counter + 1; otherwise counter holds and ovf flag <= 1.
  - On the edge where `finish_FFT` = 1, the increment still applies and the state moves to CONVERT.
  - Resulting value: if `en_FFT` is sampled at edge E0 and `finish_FFT` at edge En, the measured value is n (min 1). A value above SAT_VAL reads SAT_VAL with ovf = 1.
  - `en_FFT` is ignored in COUNT; no restart.
- CONVERT:
  - First cycle: load the shift register as {16'h0, counter}; iteration counter = 0.
  - Each following cycle: for every BCD nibble ≥ 5, add 3; then shift the whole register left by 1.
  - After exactly CNT_W shifts, go to DONE.
  - The add-3 step uses 4-bit nibble arithmetic; with counter ≤ 9999, no nibble exceeds 9 after the final shift.
- DONE (one cycle):
  - bcd_out <= upper 16 bits of the shift register; overflow <= ovf flag; bcd_valid <= 1.
  - Next state is IDLE.
  - `bcd_valid` is high for exactly one cycle and otherwise 0.
- Latency: `bcd_valid` asserts CNT_W + 2 cycles after the edge sampling `finish_FFT` (1 load + CNT_W shifts + DONE), i.e. 16 cycles at defaults.
- `busy` = 1 in COUNT and CONVERT, 0 in IDLE and DONE.
- A new `en_FFT` can be accepted on the edge after DONE; back-to-back measurements are legal.
- `bcd_out` and `overflow` are stable between `bcd_valid` pulses. A `finish_FFT` pulse with no prior start has no effect.

Test Plan:
1. Reset: assert `rst` asynchronously mid-COUNT → busy = 0, bcd_out = 0000, overflow = 0 immediately; no `bcd_valid` after release.
2. Minimum latency: `en_FFT` at E0, `finish_FFT` at E1 → `bcd_valid` one cycle, 16 cycles after E1, bcd_out = 16'h0001, overflow = 0.
3. Typical latency: n = 1234 → bcd_out = 16'h1234. Repeat with n = 9 → 16'h0009 and n = 10 → 16'h0010 (carry check).
4. Saturation: n = 9999 → 16'h9999, overflow = 0. Then n = 12000 → 16'h9999, overflow = 1. A following n = 5 → 16'h0005, overflow = 0.
5. Ignored strobes:
   - `en_FFT` and `finish_FFT` high together in IDLE → counting starts.
   - `en_FFT` re-pulsed during COUNT → no restart; n measured from the first start.
   - `finish_FFT` during CONVERT → no effect.
6. Back-to-back: second `en_FFT` on the edge after DONE → accepted. `bcd_out` holds the first result until the second `bcd_valid`.
